// File: rtl/risc_pkg.sv
// Shared decode definitions: opcode constants, instruction field positions,
// decode-stage FSM encoding and the operand-class decoder.
package risc_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_HLT = 3'b111;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, ISSUE} state_t;

  // ra/rb: register numbers for the first/second operand read
  typedef struct packed {
    logic [1:0] nreads;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wnum;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    dec_t       d;
    opc = ir[OPC_LSB +: 3];
    op  = ir[OP_LSB +: 2];
    rn  = ir[RN_LSB +: 3];
    rd  = ir[RD_LSB +: 3];
    rm  = ir[RM_LSB +: 3];
    d   = '0;
    case (opc)
      OPC_MOV: begin
        if (op == 2'b10) d.wnum = rd;
        else if (op == 2'b00) begin d.nreads = 2'd1; d.ra = rm; d.wnum = rd; end
        else d.illegal = 1'b1;
      end
      OPC_ALU: begin
        d.wnum = rd;
        if (op == 2'b11) begin d.nreads = 2'd1; d.ra = rm; end
        else begin d.nreads = 2'd2; d.ra = rn; d.rb = rm; end
      end
      OPC_LDR: begin d.nreads = 2'd1; d.ra = rn; d.wnum = rd; end
      OPC_STR: begin d.nreads = 2'd2; d.ra = rn; d.rb = rd; end
      OPC_HLT: d.nreads = 2'd0;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sign_ext.sv
// Combinational sign extension: the MSB of the input fills every upper bit.
module sign_ext #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/decode_issue_stage.sv
// Handshaked decode stage: latches an instruction, sequences register-file
// reads for its source operands, then holds the decoded bundle until taken.
module decode_issue_stage
  import risc_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int NRD    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       instr_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2:0]        rf_readnum_a,
  output logic [2:0]        rf_readnum_b,
  input  logic [WORD_W-1:0] rf_data_a,
  input  logic [WORD_W-1:0] rf_data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [2:0]        writenum,
  output logic [1:0]        shift,
  output logic [WORD_W-1:0] sximm5,
  output logic [WORD_W-1:0] sximm8,
  output logic [WORD_W-1:0] opnd_a,
  output logic [WORD_W-1:0] opnd_b,
  output logic              illegal
);

  state_t      state, state_nxt;
  dec_t        in_dec, dq;
  logic [2:0]  opc_q;
  logic [1:0]  op_q, sh_q;
  logic [7:0]  imm8_q;
  logic        accept, dual;

  assign in_dec = decode(instr_in);
  assign accept = in_valid & in_ready;
  // With two ports a two-operand instruction needs only the RD_A cycle.
  assign dual   = (NRD == 2) && (dq.nreads == 2'd2);

  always_comb begin
    state_nxt    = state;
    rf_readnum_a = 3'd0;
    rf_readnum_b = 3'd0;
    case (state)
      IDLE:
        if (in_valid) state_nxt = (in_dec.nreads == 2'd0) ? ISSUE : RD_A;
      RD_A: begin
        rf_readnum_a = dq.ra;
        if (dual) rf_readnum_b = dq.rb;
        state_nxt = (dq.nreads == 2'd2 && !dual) ? RD_B : ISSUE;
      end
      RD_B: begin
        rf_readnum_a = dq.rb;
        state_nxt    = ISSUE;
      end
      ISSUE:
        if (out_ready) begin
          if (in_valid) state_nxt = (in_dec.nreads == 2'd0) ? ISSUE : RD_A;
          else          state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) || (state == ISSUE && out_ready);
  assign out_valid = (state == ISSUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      dq     <= '0;
      opc_q  <= '0;
      op_q   <= '0;
      sh_q   <= '0;
      imm8_q <= '0;
      opnd_a <= '0;
      opnd_b <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dq     <= in_dec;
        opc_q  <= instr_in[OPC_LSB +: 3];
        op_q   <= instr_in[OP_LSB +: 2];
        sh_q   <= instr_in[SH_LSB +: 2];
        imm8_q <= instr_in[7:0];
        opnd_a <= '0;
        opnd_b <= '0;
      end else begin
        if (state == RD_A) begin
          opnd_a <= rf_data_a;
          if (dual) opnd_b <= rf_data_b;
        end
        // single-port second read comes back on port A
        if (state == RD_B) opnd_b <= rf_data_a;
      end
    end
  end

  assign opcode   = opc_q;
  assign op       = op_q;
  assign shift    = sh_q;
  assign writenum = dq.wnum;
  assign illegal  = dq.illegal;

  sign_ext #(.IN_W(5), .OUT_W(WORD_W)) u_sx5 (.din(imm8_q[4:0]), .dout(sximm5));
  sign_ext #(.IN_W(8), .OUT_W(WORD_W)) u_sx8 (.din(imm8_q),      .dout(sximm8));

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: a 16-bit single-port instance and a 32-bit
// dual-port instance checked against a rule-level reference model.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n, sel;
  logic [15:0] instr_in;
  logic        in_valid, out_ready;
  logic [31:0] rf [8];
  int          checks = 0, failures = 0;

  logic        in_ready1, out_valid1, illegal1;
  logic [2:0]  rna1, rnb1, opc1, wr1;
  logic [1:0]  op1, sh1;
  logic [15:0] rda1, rdb1, sx5_1, sx8_1, oa1, ob1;

  logic        in_ready2, out_valid2, illegal2;
  logic [2:0]  rna2, rnb2, opc2, wr2;
  logic [1:0]  op2, sh2;
  logic [31:0] rda2, rdb2, sx5_2, sx8_2, oa2, ob2;

  always #5 clk = ~clk;

  assign rda1 = rf[rna1][15:0];
  assign rdb1 = rf[rnb1][15:0];
  assign rda2 = rf[rna2];
  assign rdb2 = rf[rnb2];

  decode_issue_stage #(.WORD_W(16), .NRD(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in),
    .in_valid(in_valid & ~sel), .in_ready(in_ready1),
    .rf_readnum_a(rna1), .rf_readnum_b(rnb1), .rf_data_a(rda1), .rf_data_b(rdb1),
    .out_valid(out_valid1), .out_ready(out_ready & ~sel),
    .opcode(opc1), .op(op1), .writenum(wr1), .shift(sh1),
    .sximm5(sx5_1), .sximm8(sx8_1), .opnd_a(oa1), .opnd_b(ob1), .illegal(illegal1)
  );

  decode_issue_stage #(.WORD_W(32), .NRD(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in),
    .in_valid(in_valid & sel), .in_ready(in_ready2),
    .rf_readnum_a(rna2), .rf_readnum_b(rnb2), .rf_data_a(rda2), .rf_data_b(rdb2),
    .out_valid(out_valid2), .out_ready(out_ready & sel),
    .opcode(opc2), .op(op2), .writenum(wr2), .shift(sh2),
    .sximm5(sx5_2), .sximm8(sx8_2), .opnd_a(oa2), .opnd_b(ob2), .illegal(illegal2)
  );

  logic        m_in_ready, m_out_valid, m_ill;
  logic [2:0]  m_rna, m_rnb, m_opc, m_wr;
  logic [1:0]  m_op, m_sh;
  logic [31:0] m_sx5, m_sx8, m_oa, m_ob;

  assign m_in_ready  = sel ? in_ready2  : in_ready1;
  assign m_out_valid = sel ? out_valid2 : out_valid1;
  assign m_ill       = sel ? illegal2   : illegal1;
  assign m_rna       = sel ? rna2 : rna1;
  assign m_rnb       = sel ? rnb2 : rnb1;
  assign m_opc       = sel ? opc2 : opc1;
  assign m_wr        = sel ? wr2  : wr1;
  assign m_op        = sel ? op2  : op1;
  assign m_sh        = sel ? sh2  : sh1;
  assign m_sx5       = sel ? sx5_2 : {16'h0, sx5_1};
  assign m_sx8       = sel ? sx8_2 : {16'h0, sx8_1};
  assign m_oa        = sel ? oa2 : {16'h0, oa1};
  assign m_ob        = sel ? ob2 : {16'h0, ob1};

  typedef struct {
    logic [2:0]  opc, wr, sa0, sa1, sb0, sb1;
    logic [1:0]  op, sh;
    logic [31:0] sx5, sx8, oa, ob;
    logic        ill;
    int          lat, nrc;
  } exp_t;

  // Expected bundle from the operand-class table; width/ports follow sel.
  function automatic exp_t model(input logic [15:0] ins);
    exp_t        e;
    logic [2:0]  rn, rd, rm, a, b;
    logic [31:0] mask;
    int          nr;
    mask  = sel ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    e.opc = ins[15:13]; e.op = ins[12:11]; e.sh = ins[4:3];
    rn = ins[10:8]; rd = ins[7:5]; rm = ins[2:0];
    nr = 0; a = 3'd0; b = 3'd0; e.ill = 1'b0;
    case (e.opc)
      3'b110: if (e.op == 2'b10) nr = 0;
              else if (e.op == 2'b00) begin nr = 1; a = rm; end
              else e.ill = 1'b1;
      3'b101: if (e.op == 2'b11) begin nr = 1; a = rm; end
              else begin nr = 2; a = rn; b = rm; end
      3'b011: begin nr = 1; a = rn; end
      3'b100: begin nr = 2; a = rn; b = rd; end
      3'b111: nr = 0;
      default: e.ill = 1'b1;
    endcase
    e.wr  = ((e.opc == 3'b110 && !e.ill) || e.opc == 3'b101 || e.opc == 3'b011) ? rd : 3'd0;
    e.sx5 = (ins[4] ? (32'hFFFF_FFE0 | 32'(ins[4:0])) : 32'(ins[4:0])) & mask;
    e.sx8 = (ins[7] ? (32'hFFFF_FF00 | 32'(ins[7:0])) : 32'(ins[7:0])) & mask;
    e.oa  = (nr >= 1) ? (rf[a] & mask) : 32'd0;
    e.ob  = (nr == 2) ? (rf[b] & mask) : 32'd0;
    e.lat = (nr == 0) ? 1 : (nr == 2 && !sel) ? 3 : 2;
    e.nrc = e.lat - 1;
    e.sa0 = a;
    e.sb0 = (nr == 2 && sel) ? b : 3'd0;
    e.sa1 = b;
    e.sb1 = 3'd0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, sel, obs, exp);
    end
  endtask

  task automatic check_bundle(input exp_t e);
    check("out_valid", 32'(m_out_valid), 32'd1);
    check("opcode",    32'(m_opc), 32'(e.opc));
    check("op",        32'(m_op),  32'(e.op));
    check("writenum",  32'(m_wr),  32'(e.wr));
    check("shift",     32'(m_sh),  32'(e.sh));
    check("sximm5",    m_sx5, e.sx5);
    check("sximm8",    m_sx8, e.sx8);
    check("opnd_a",    m_oa,  e.oa);
    check("opnd_b",    m_ob,  e.ob);
    check("illegal",   32'(m_ill), 32'(e.ill));
  endtask

  task automatic check_zero();
    check("z_out_valid", 32'(m_out_valid), 32'd0);
    check("z_in_ready",  32'(m_in_ready),  32'd1);
    check("z_readnums",  {26'd0, m_rna, m_rnb}, 32'd0);
    check("z_fields",    {22'd0, m_opc, m_op, m_wr, m_sh}, 32'd0);
    check("z_imms",      m_sx5 | m_sx8, 32'd0);
    check("z_opnds",     m_oa | m_ob, 32'd0);
    check("z_illegal",   32'(m_ill), 32'd0);
  endtask

  // Issue one instruction from IDLE, track read cycles and latency, then drain.
  task automatic run(input logic [15:0] ins);
    exp_t       e;
    int         cyc;
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    e = model(ins);
    @(negedge clk);
    check("in_ready_idle", 32'(m_in_ready), 32'd1);
    instr_in = ins; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!m_out_valid && cyc < 8) begin
      check("in_ready_busy", 32'(m_in_ready), 32'd0);
      qa.push_back(m_rna); qb.push_back(m_rnb);
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(e.lat));
    check("read_cycles", 32'(qa.size()), 32'(e.nrc));
    for (int i = 0; i < qa.size() && i < 2; i++) begin
      check("readnum_a", 32'(qa[i]), 32'(i == 0 ? e.sa0 : e.sa1));
      check("readnum_b", 32'(qb[i]), 32'(i == 0 ? e.sb0 : e.sb1));
    end
    check_bundle(e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drained", 32'(m_out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    reset_n = 1'b0; sel = 1'b0; instr_in = 16'h0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_zero();
    sel = 1'b1; #1;
    check_zero();
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero();

    // single-port 16-bit instance
    rf[2] = 32'd7; rf[5] = 32'd9;
    run(16'hA225);
    run(16'hD0FF);
    run(16'hD07F);
    run(16'hD010);
    run(16'h2000);
    run(16'hD07F);

    // backpressure, then back-to-back MOV imm with no bubble
    e = model(16'hA225);
    @(negedge clk);
    instr_in = 16'hA225; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!m_out_valid && n < 8) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      check_bundle(e);
      check("bp_in_ready", 32'(m_in_ready), 32'd0);
      @(negedge clk);
    end
    e = model(16'hD081);
    instr_in = 16'hD081; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check_bundle(e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_drained", 32'(m_out_valid), 32'd0);

    // reset during the RD_B cycle of a STR
    @(negedge clk);
    instr_in = 16'h83C0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("str_rd_b_num", 32'(m_rna), 32'd6);
    reset_n = 1'b0;
    #1;
    check_zero();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(m_out_valid), 32'd0);
    end
    run(16'h83C0);

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 8; i++) rf[i] = $urandom();
      run(16'($urandom()));
    end

    // dual-port 32-bit instance
    sel = 1'b1;
    rf[2] = 32'd7; rf[5] = 32'd9;
    run(16'hA225);
    run(16'hD010);
    run(16'h83C0);
    run(16'h2000);
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 8; i++) rf[i] = $urandom();
      run(16'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
